scan_mux: RTL

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 13 +
 rtl/scan_mux_sel.sv | 23 ++
 rtl/scan_mux.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and default parameter values for the scan_mux channel selector.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    localparam int unsigned DefNCh = 4;
    localparam int unsigned DefW   = 1;

endpackage

// File: rtl/scan_mux_sel.sv
// Combinational N_CH:1 slice selector; an index past the last channel yields zero.
module scan_mux_sel
    import scan_mux_pkg::*;
#(
    parameter int unsigned N_CH  = DefNCh,
    parameter int unsigned W     = DefW,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] number,
    input  logic [SEL_W-1:0]  idx,
    output logic [W-1:0]      data
);

    always_comb begin
        data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                data = number[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with direct-select and auto-scan modes behind a valid/ready output.
// Define SCAN_MUX_PARITY_EN to add the registered y_par output (XOR of Y).
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned N_CH  = DefNCh,
    parameter int unsigned W     = DefW,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] number,
    input  logic [SEL_W-1:0]  selection,
    input  logic              req,
    input  logic              start,
    input  logic              y_ready,
    output logic [W-1:0]      Y,
    output logic              y_valid,
    output logic [SEL_W-1:0]  ch_idx,
    output logic              y_last,
    output logic              busy,
    output logic              sel_err
`ifdef SCAN_MUX_PARITY_EN
    ,
    output logic              y_par
`endif
);

    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N_CH - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     y_q, y_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] sel_idx;
    logic [W-1:0]     sel_data;

    scan_mux_sel #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .number (number),
        .idx    (sel_idx),
        .data   (sel_data)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        sel_idx = '0;
        unique case (state_q)
            StIdle: begin
                // req has priority; a coincident start is dropped
                if (req) begin
                    sel_idx = selection;
                    y_d     = sel_data;
                    idx_d   = selection;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    err_d   = (32'(selection) >= N_CH);
                    state_d = StDirect;
                end else if (start) begin
                    sel_idx = '0;
                    y_d     = sel_data;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (LastIdx == '0);
                    state_d = StScan;
                end
            end
            StDirect: begin
                if (valid_q && y_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StScan: begin
                if (valid_q && y_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        // next channel is sampled on the same edge the current beat completes
                        sel_idx = idx_q + SEL_W'(1);
                        y_d     = sel_data;
                        idx_d   = sel_idx;
                        last_d  = (sel_idx == LastIdx);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            y_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

`ifdef SCAN_MUX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^y_d;
        end
    end

    assign y_par = par_q;
`endif

    assign Y       = y_q;
    assign y_valid = valid_q;
    assign ch_idx  = idx_q;
    assign y_last  = last_q;
    assign busy    = (state_q != StIdle);
    assign sel_err = err_q;

endmodule
